jk_bank_arbiter: RTL and testbench
==================================

# jk_bank_arbiter

Shared-register controller that arbitrates a bank of WIDTH JK flip-flops between NREQ requesters. Each requester issues JK commands (hold/clear/set/toggle) under a per-bit mask. A round-robin arbiter grants one requester at a time, with an optional bounded lock for multi-cycle ownership. The block sits between the status/flag producers of a subsystem and the flag register they share, so that no two writers can drive J/K on the same edge.

## Interface
- WIDTH, 8, number of JK bits in the bank (1..32)
- NREQ, 4, number of requesters (2..8)
- MAX_HOLD, 4, maximum consecutive commands one locked grant may apply (1..15)

- CP  in  1  clock; all state changes on posedge
- CD  in  1  reset, asynchronous, active-high; clears all state
- req  in  NREQ  per-requester request; held until granted
- lock  in  NREQ  per-requester request to keep the grant after the current command
- cmd  in  2*NREQ  requester i at [2i+1:2i]: {J,K} = 00 hold, 01 clear, 10 set, 11 toggle
- mask  in  WIDTH*NREQ  requester i at [WIDTH*i +: WIDTH]; 1 = bit affected
- gnt  out  NREQ  registered one-hot grant, or all-zero
- Q  out  WIDTH  bank contents
- QN  out  WIDTH  ~Q, combinational
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse after an edge on which a command was applied

## Operation
- Reset (CD=1, immediate, async): Q=0, QN=all ones, gnt=0, busy=0, done=0, rr pointer=0, hold count=0, state IDLE.
- States: IDLE, GRANT, LOCKED.
- IDLE: if any req high at an edge, gnt[w] is set, where w is the first requester with req set, searching from pointer upward and wrapping modulo NREQ. State goes to GRANT. With no requests, stay in IDLE.
- GRANT/LOCKED, edge with req[w]=1 (command fires):
  - Masked bits update per cmd_w: 01 → 0, 10 → 1, 11 → ~Q, 00 → unchanged. Unmasked bits are always held. done=1 next cycle.
  - hold count increments.
  - If lock[w]=1 and the new hold count < MAX_HOLD: keep gnt, go to LOCKED.
  - Otherwise: gnt=0, pointer=(w+1) mod NREQ, hold count=0, go to IDLE.
- GRANT/LOCKED, edge with req[w]=0 (requester withdrew): no command, gnt=0, pointer=(w+1) mod NREQ, hold count=0, go to IDLE.
- Only the granted requester's cmd/mask reach the bank. All other requesters see J=K=0 on every bit.
- Requests from non-granted requesters are ignored until the state returns to IDLE. There is no queuing inside the block; the requester holds req.
- Hold count width is clog2(MAX_HOLD+1). A lock with MAX_HOLD=1 behaves as no lock.

## Timing
- Request-to-grant: req high before edge k → gnt high after edge k.
- First command applies at edge k+1. Q and done are valid after edge k+1.
- Unlocked grant occupies 2 cycles (IDLE + GRANT). The next requester can be granted at edge k+2 at the earliest. Peak throughput is 1 command per 2 cycles.
- Locked grant applies up to MAX_HOLD commands on consecutive edges, then is force-released.
- Reset asserted mid-grant aborts immediately. Q clears even if a command would have fired on the same edge. After CD deasserts, the first grant needs a fresh request edge.
- QN follows Q combinationally and has no extra latency.

## Structure
- Shared package jk_bank_pkg: command encodings (JK_HOLD, JK_CLR, JK_SET, JK_TGL), the state enum (IDLE/GRANT/LOCKED), and a round-robin first-one-from-pointer function.
- Sub-module jk_reg_bank: WIDTH JK cells with clock CP and async clear, taking per-bit J/K vectors. It contains no arbitration logic.
- The arbiter FSM, pointer and hold counter live in the top level.

## Test plan
- Reset: drive CD=1 mid-operation with Q=8'hA5 → Q=0, QN=8'hFF, gnt=0 and busy=0 immediately, without waiting for a CP edge.
- Single set: req0=1, cmd0=10, mask0=8'h0F → gnt=0001 after edge 1, Q=8'h0F and done=1 after edge 2, gnt=0 after edge 2.
- Round-robin: all four requesters hold req continuously, no lock → grant order 0,1,2,3,0, with one grant per 2 cycles and none skipped.
- Lock bound: with MAX_HOLD=4, req1 and lock1 held, cmd1=11, mask1=8'h01, starting from Q=0 → 4 consecutive toggles (Q bit0: 1,0,1,0), then gnt=0 and pointer=2.
- Withdrawal: req2 drops in the cycle after gnt2 rises → Q unchanged, no done pulse, gnt=0, the next grant searches from requester 3.
- Mask isolation: granted cmd=01 with mask=8'hF0 on Q=8'hFF → Q=8'h0F. Non-granted requesters driving cmd=10 with mask=8'hFF have no effect.

Source files
------------

// File: rtl/jk_bank_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : jk_bank_pkg
// Brief   : Shared JK command encodings, arbiter state type and the
//           round-robin first-one-from-pointer search.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package jk_bank_pkg;

  // {J,K} command encodings
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Largest requester count the search function handles
  localparam int RR_MAX = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // First requester with its bit set, searching from ptr upward and wrapping
  // modulo n. ptr must be below n; the result is ptr when nothing is set.
  function automatic logic [2:0] rr_first(input logic [RR_MAX-1:0] reqv,
                                          input logic [2:0] ptr,
                                          input logic [3:0] n);
    logic [2:0] sel;
    logic       found;
    logic [3:0] idx;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= n) idx = idx - n;
      if (!found && (4'(i) < n) && reqv[idx[2:0]]) begin
        sel   = idx[2:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jk_reg_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : jk_reg_bank
// Brief   : WIDTH independent JK flip-flops with asynchronous clear.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module jk_reg_bank #(
  parameter int WIDTH = 8
) (
  input  logic             CP,
  input  logic             CD,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  // Characteristic JK equation per bit: Q+ = J&~Q | ~K&Q
  always_ff @(posedge CP or posedge CD) begin
    if (CD) q <= '0;
    else    q <= (j & ~q) | (~k & q);
  end

endmodule
`default_nettype wire

// File: rtl/jk_bank_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : jk_bank_arbiter
// Brief   : Round-robin arbiter granting one requester at a time access to a
//           shared JK flag bank, with a bounded multi-command lock.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module jk_bank_arbiter
  import jk_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                  CP,
  input  logic                  CD,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [2*NREQ-1:0]     cmd,
  input  logic [WIDTH*NREQ-1:0] mask,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      Q,
  output logic [WIDTH-1:0]      QN,
  output logic                  busy,
  output logic                  done
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  state_t        state;
  logic [2:0]    widx;      // index of the granted requester
  logic [2:0]    ptr;       // round-robin search start
  logic [HW-1:0] hcnt;

  logic [RR_MAX-1:0] req_pad, lock_pad;
  logic [2:0]        pick, ptr_nxt;
  logic [NREQ-1:0]   gnt_pick;
  logic [1:0]        cmd_sel;
  logic [WIDTH-1:0]  mask_sel, j, k;
  logic [HW-1:0]     hcnt_inc;
  logic              fire;

  // Granted requester's command/mask selection and search bookkeeping
  always_comb begin
    req_pad  = '0;
    lock_pad = '0;
    req_pad[NREQ-1:0]  = req;
    lock_pad[NREQ-1:0] = lock;
    pick     = rr_first(req_pad, ptr, 4'(NREQ));
    gnt_pick = '0;
    cmd_sel  = JK_HOLD;
    mask_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == 3'(i)) gnt_pick[i] = 1'b1;
      if (widx == 3'(i)) begin
        cmd_sel  = cmd[2*i +: 2];
        mask_sel = mask[WIDTH*i +: WIDTH];
      end
    end
    ptr_nxt  = (widx == 3'(NREQ - 1)) ? 3'd0 : widx + 3'd1;
    hcnt_inc = hcnt + HW'(1);
    fire     = (state != IDLE) && req_pad[widx];
    // Only the owner drives J/K; everyone else sees hold on every bit
    j = fire ? (mask_sel & {WIDTH{cmd_sel[1]}}) : '0;
    k = fire ? (mask_sel & {WIDTH{cmd_sel[0]}}) : '0;
  end

  // Arbiter FSM: grant in IDLE, apply/extend/release in GRANT and LOCKED
  always_ff @(posedge CP or posedge CD) begin
    if (CD) begin
      state <= IDLE;
      gnt   <= '0;
      widx  <= '0;
      ptr   <= '0;
      hcnt  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            widx  <= pick;
            gnt   <= gnt_pick;
            state <= GRANT;
          end
        end
        GRANT, LOCKED: begin
          if (fire) done <= 1'b1;
          if (fire && lock_pad[widx] && (hcnt_inc < HW'(MAX_HOLD))) begin
            hcnt  <= hcnt_inc;
            state <= LOCKED;
          end else begin
            // Command limit reached, no lock, or requester withdrew
            gnt   <= '0;
            ptr   <= ptr_nxt;
            hcnt  <= '0;
            state <= IDLE;
          end
        end
        default: begin
          gnt   <= '0;
          hcnt  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  jk_reg_bank #(.WIDTH(WIDTH)) u_bank (
    .CP (CP),
    .CD (CD),
    .j  (j),
    .k  (k),
    .q  (Q)
  );

  assign QN   = ~Q;
  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_jk_bank_arbiter
// Brief   : Directed self-checking bench for jk_bank_arbiter
//           (WIDTH=8, NREQ=4, MAX_HOLD=4).
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_jk_bank_arbiter;

  logic        CP = 1'b0;
  logic        CD = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  lock = '0;
  logic [7:0]  cmd = '0;
  logic [31:0] mask = '0;
  logic [3:0]  gnt;
  logic [7:0]  Q, QN;
  logic        busy, done;

  int tests = 0;
  int fails = 0;

  jk_bank_arbiter #(.WIDTH(8), .NREQ(4), .MAX_HOLD(4)) dut (
    .CP   (CP),
    .CD   (CD),
    .req  (req),
    .lock (lock),
    .cmd  (cmd),
    .mask (mask),
    .gnt  (gnt),
    .Q    (Q),
    .QN   (QN),
    .busy (busy),
    .done (done)
  );

  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic step();
    @(posedge CP);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] c, input logic [7:0] m);
    cmd[2*i +: 2] = c;
    mask[8*i +: 8] = m;
  endtask

  logic [3:0] rr_exp [10];

  initial begin
    rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
               4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};

    // Reset state
    step();
    chk("rst_q", Q, 8'h00);
    chk("rst_qn", QN, 8'hFF);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    CD = 1'b0;
    step();
    chk("idle_gnt", gnt, 4'b0000);

    // Single set from requester 0
    set_req(0, 2'b10, 8'h0F);
    req = 4'b0001;
    step();
    chk("set_gnt", gnt, 4'b0001);
    chk("set_busy", busy, 1'b1);
    chk("set_q_early", Q, 8'h00);
    step();
    chk("set_q", Q, 8'h0F);
    chk("set_qn", QN, 8'hF0);
    chk("set_done", done, 1'b1);
    chk("set_gnt_rel", gnt, 4'b0000);
    req = 4'b0000;
    step();
    chk("set_done_pulse", done, 1'b0);
    chk("set_busy_idle", busy, 1'b0);

    // Requester 1 sets all bits (pointer now 1)
    set_req(1, 2'b10, 8'hFF);
    req = 4'b0010;
    step();
    chk("r1_gnt", gnt, 4'b0010);
    step();
    chk("r1_q", Q, 8'hFF);
    req = 4'b0000;

    // Mask isolation: owner 0 clears high nibble, others drive set/FF without req
    set_req(0, 2'b01, 8'hF0);
    set_req(1, 2'b10, 8'hFF);
    set_req(2, 2'b10, 8'hFF);
    set_req(3, 2'b10, 8'hFF);
    req = 4'b0001;
    step();
    chk("iso_gnt", gnt, 4'b0001);
    step();
    chk("iso_q", Q, 8'h0F);
    req = 4'b0000;
    step();
    chk("iso_q_hold", Q, 8'h0F);

    // Withdrawal: requester 2 drops right after being granted
    req = 4'b0100;
    step();
    chk("wd_gnt", gnt, 4'b0100);
    req = 4'b0000;
    step();
    chk("wd_q", Q, 8'h0F);
    chk("wd_done", done, 1'b0);
    chk("wd_gnt_rel", gnt, 4'b0000);
    // Pointer should now be 3: requesters 2 and 3 both ask, 3 wins
    set_req(3, 2'b00, 8'hFF);
    req = 4'b1100;
    step();
    chk("wd_next_gnt", gnt, 4'b1000);
    step();
    chk("wd_hold_q", Q, 8'h0F);
    chk("wd_hold_done", done, 1'b1);
    req = 4'b0000;
    step();

    // Round-robin: all request continuously with hold commands
    for (int i = 0; i < 4; i++) set_req(i, 2'b00, 8'hFF);
    req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("rr_gnt%0d", i), gnt, rr_exp[i]);
    end
    req = 4'b0000;
    chk("rr_q", Q, 8'h0F);

    // Clear the bank via requester 0 (pointer 1 -> search 1,2,3,0)
    set_req(0, 2'b01, 8'hFF);
    req = 4'b0001;
    step();
    step();
    chk("clr_q", Q, 8'h00);
    req = 4'b0000;
    step();

    // Lock bound: requester 1 toggles bit 0 four times, then forced release
    set_req(1, 2'b11, 8'h01);
    req  = 4'b0010;
    lock = 4'b0010;
    step();
    chk("lk_gnt", gnt, 4'b0010);
    step();
    chk("lk_q1", Q, 8'h01);
    chk("lk_gnt1", gnt, 4'b0010);
    step();
    chk("lk_q2", Q, 8'h00);
    chk("lk_done2", done, 1'b1);
    step();
    chk("lk_q3", Q, 8'h01);
    chk("lk_gnt3", gnt, 4'b0010);
    step();
    chk("lk_q4", Q, 8'h00);
    chk("lk_gnt_rel", gnt, 4'b0000);
    chk("lk_busy_rel", busy, 1'b0);
    // Pointer should be 2: requesters 1 and 2 ask, 2 wins
    lock = 4'b0000;
    set_req(2, 2'b00, 8'h00);
    req = 4'b0110;
    step();
    chk("lk_ptr_gnt", gnt, 4'b0100);
    step();
    req = 4'b0000;
    chk("lk_after_q", Q, 8'h00);

    // Load A5 via requester 3, then reset asynchronously mid-grant
    set_req(3, 2'b10, 8'hA5);
    req = 4'b1000;
    step();
    step();
    chk("ar_q_pre", Q, 8'hA5);
    set_req(0, 2'b10, 8'hFF);
    req = 4'b0001;
    step();
    chk("ar_gnt_pre", gnt, 4'b0001);
    #2;
    CD = 1'b1;
    #1;
    chk("ar_q", Q, 8'h00);
    chk("ar_qn", QN, 8'hFF);
    chk("ar_gnt", gnt, 4'b0000);
    chk("ar_busy", busy, 1'b0);
    step();
    chk("ar_q_hold", Q, 8'h00);
    CD  = 1'b0;
    req = 4'b0000;
    step();
    chk("ar_idle_gnt", gnt, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
